// File: rtl/tl_sensor_cond.sv
// Traffic-sensor conditioner: two-flop synchronizer, consecutive-sample debounce
// and saturating car counter for each of the two street sensors.
module tl_sensor_cond #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sa_raw,
  input  logic             sb_raw,
  input  logic             cnt_clr,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] car_cnt_a,
  output logic [CNT_W-1:0] car_cnt_b
);

  localparam int              DB_W   = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       raw;
  logic [1:0]       t_lvl;
  logic [CNT_W-1:0] cnt [2];

  assign raw = {sb_raw, sa_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             sync_p0;
    logic             sync_p1;
    logic [DB_W-1:0]  db_cnt;
    logic             t_q;
    logic [CNT_W-1:0] car_cnt;
    logic             flip;

    // Output toggles once the synchronized level has disagreed for DB_CYCLES samples
    assign flip = (sync_p1 != t_q) && (db_cnt == DB_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        db_cnt  <= '0;
        t_q     <= 1'b0;
        car_cnt <= '0;
      end else begin
        // stage p0 -> p1: metastability synchronizer
        sync_p0 <= raw[g];
        sync_p1 <= sync_p0;
        // debounce stage
        if (sync_p1 == t_q) begin
          db_cnt <= '0;
        end else if (flip) begin
          db_cnt <= '0;
          t_q    <= sync_p1;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
        // clear beats a coincident rising edge
        if (cnt_clr) begin
          car_cnt <= '0;
        end else if (flip && !t_q) begin
          car_cnt <= sat_inc(car_cnt);
        end
      end
    end

    assign t_lvl[g] = t_q;
    assign cnt[g]   = car_cnt;
  end

  assign Ta        = t_lvl[0];
  assign Tb        = t_lvl[1];
  assign car_cnt_a = cnt[0];
  assign car_cnt_b = cnt[1];

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Randomized and directed bench for tl_sensor_cond against a sample-window model.
module tb_tl_sensor_cond;
  localparam int DB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sa_raw = 1'b0;
  logic          sb_raw = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          Ta, Tb;
  logic [CW-1:0] car_cnt_a, car_cnt_b;

  int checks = 0;
  int failures = 0;

  // Model: raw samples per channel, newest at index 0; level flips when the
  // samples taken 2..DB+1 edges ago all disagree with the current level.
  bit win [2][DB+2];
  bit m_t [2];
  int m_cnt [2];

  tl_sensor_cond #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sa_raw(sa_raw), .sb_raw(sb_raw),
    .cnt_clr(cnt_clr), .Ta(Ta), .Tb(Tb),
    .car_cnt_a(car_cnt_a), .car_cnt_b(car_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_t[c] = 1'b0;
      m_cnt[c] = 0;
      for (int i = 0; i < DB + 2; i++) win[c][i] = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".Ta"}, Ta, m_t[0]);
    chk({tag, ".Tb"}, Tb, m_t[1]);
    chk({tag, ".cnt_a"}, car_cnt_a, m_cnt[0]);
    chk({tag, ".cnt_b"}, car_cnt_b, m_cnt[1]);
  endtask

  task automatic step(input string tag);
    bit flip;
    @(posedge clk);
    if (reset_n) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = DB + 1; i > 0; i--) win[c][i] = win[c][i-1];
        win[c][0] = (c == 0) ? sa_raw : sb_raw;
        flip = 1'b1;
        for (int i = 2; i <= DB + 1; i++) if (win[c][i] == m_t[c]) flip = 1'b0;
        if (cnt_clr) m_cnt[c] = 0;
        else if (flip && !m_t[c] && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
        if (flip) m_t[c] = !m_t[c];
      end
    end
    #1;
    compare_all(tag);
  endtask

  // Called 1 ns after an edge: asserts reset mid-cycle, holds it, releases mid-cycle.
  task automatic async_rst(input int hold_edges);
    #3;
    reset_n = 1'b0;
    #1;
    model_clear();
    compare_all("async_rst");
    repeat (hold_edges) step("in_rst");
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    int rem_a, rem_b, hi_cnt, min_tb;
    model_clear();

    // Reset values with sensors high
    sa_raw = 1'b1;
    sb_raw = 1'b1;
    #2;
    compare_all("rst_hold");
    repeat (3) step("rst_hold");
    #3;
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step("rst_rel");
      chk("rst_rel_Ta_edge", Ta, (i == 6));
    end
    chk("rst_rel_cnt_a", car_cnt_a, 1);
    sa_raw = 1'b0;
    sb_raw = 1'b0;
    repeat (8) step("settle");

    // Clear, then latency up and down
    cnt_clr = 1'b1;
    step("clr");
    cnt_clr = 1'b0;
    chk("clr_cnt_a", car_cnt_a, 0);
    sa_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step("lat_up");
      chk("lat_up_Ta", Ta, (i >= 6));
    end
    sa_raw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step("lat_dn");
      chk("lat_dn_Ta", Ta, (i < 6));
    end
    chk("lat_cnt_a", car_cnt_a, 1);
    chk("lat_Tb", Tb, 0);

    // Glitch rejection on B
    sb_raw = 1'b1;
    repeat (3) step("glitch3");
    sb_raw = 1'b0;
    repeat (8) step("glitch3");
    chk("glitch3_cnt_b", car_cnt_b, 0);
    hi_cnt = 0;
    sb_raw = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) sb_raw = 1'b0;
      step("pulse4");
      if (Tb) hi_cnt++;
    end
    chk("pulse4_width", hi_cnt, 4);
    chk("pulse4_cnt_b", car_cnt_b, 1);
    sb_raw = 1'b1;
    repeat (8) step("dropout");
    min_tb = 1;
    sb_raw = 1'b0;
    repeat (2) begin step("dropout"); if (!Tb) min_tb = 0; end
    sb_raw = 1'b1;
    repeat (8) begin step("dropout"); if (!Tb) min_tb = 0; end
    chk("dropout_Tb_held", min_tb, 1);
    sb_raw = 1'b0;
    repeat (8) step("dropout");
    chk("dropout_cnt_b", car_cnt_b, 2);

    // Saturation and clear
    for (int p = 0; p < 257; p++) begin
      sa_raw = 1'b1;
      repeat (8) step("sat");
      sa_raw = 1'b0;
      repeat (8) step("sat");
    end
    chk("sat_cnt_a", car_cnt_a, 255);
    cnt_clr = 1'b1;
    step("sat_clr");
    cnt_clr = 1'b0;
    chk("sat_clr_a", car_cnt_a, 0);
    chk("sat_clr_b", car_cnt_b, 0);
    sa_raw = 1'b1;
    repeat (5) step("clr_rise");
    cnt_clr = 1'b1;
    step("clr_rise");
    cnt_clr = 1'b0;
    chk("clr_rise_Ta", Ta, 1);
    chk("clr_rise_cnt_a", car_cnt_a, 0);
    sa_raw = 1'b0;
    repeat (8) step("settle");

    // Async reset mid-debounce on A while Tb is high
    sb_raw = 1'b1;
    repeat (8) step("pre_rst");
    sa_raw = 1'b1;
    repeat (3) step("pre_rst");
    chk("pre_rst_Tb", Tb, 1);
    async_rst(2);
    for (int i = 1; i <= 6; i++) begin
      step("post_rst");
      chk("post_rst_Ta", Ta, (i == 6));
      chk("post_rst_Tb", Tb, (i == 6));
    end
    chk("post_rst_cnt_a", car_cnt_a, 1);
    chk("post_rst_cnt_b", car_cnt_b, 1);

    // Randomized run lengths, clears and occasional async resets
    rem_a = 0;
    rem_b = 0;
    for (int n = 0; n < 4000; n++) begin
      if (rem_a == 0) begin sa_raw = ~sa_raw; rem_a = $urandom_range(1, 8); end
      if (rem_b == 0) begin sb_raw = ~sb_raw; rem_b = $urandom_range(1, 8); end
      rem_a--;
      rem_b--;
      cnt_clr = ($urandom_range(0, 31) == 0);
      step("rand");
      if ($urandom_range(0, 499) == 0) async_rst($urandom_range(0, 2));
    end
    cnt_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_sensor_cond.md
# tl_sensor_cond

Traffic-sensor conditioner that sits directly upstream of the traffic-light controller and drives its `Ta`/`Tb` inputs. It synchronizes the two raw street sensors, debounces each one with a consecutive-sample filter, and presents clean, glitch-free traffic-present levels. It also keeps a saturating per-street car count (debounced rising edges) for status readout.

## Interface

- `DB_CYCLES`, default 4: consecutive synchronized samples that must disagree with the current output before it changes. Legal range is 2..255.
- `CNT_W`, default 8: width of each car counter.

Ports:

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sa_raw`  in  1  raw street-A sensor. Asynchronous to `clk`; 1 means a vehicle is present.
- `sb_raw`  in  1  raw street-B sensor. Same rules as `sa_raw`.
- `cnt_clr`  in  1  synchronous clear of both car counters.
- `Ta`  out  1  debounced street-A traffic present. Registered.
- `Tb`  out  1  debounced street-B traffic present. Registered.
- `car_cnt_a`  out  CNT_W  number of debounced 0->1 transitions of `Ta`. Saturating.
- `car_cnt_b`  out  CNT_W  number of debounced 0->1 transitions of `Tb`. Saturating.

## Operation

- The two channels (A, B) are identical and fully independent. Channel A is described here.
- **Synchronizer**
  - Two flops in series: `sa_raw` -> `s1` -> `s2`.
  - Only `s2` is used downstream.
- **Debounce counter**
  - Counter `db_cnt`, width ceil(log2(DB_CYCLES)), one per channel.
  - If `s2 == Ta`: `db_cnt` <= 0.
  - If `s2 != Ta` and `db_cnt == DB_CYCLES-1`: `Ta` <= `s2` and `db_cnt` <= 0.
  - If `s2 != Ta` otherwise: `db_cnt` <= `db_cnt` + 1.
  - A pulse on `s2` shorter than DB_CYCLES cycles never reaches `Ta`. The counter restarts from 0 whenever `s2` returns to equal `Ta`.
  - Rising and falling transitions are filtered symmetrically.
- **Car counter**
  - Increments on the same edge at which `Ta` goes 0->1.
  - Holds at all-ones: no wrap.
  - A 1->0 transition of `Ta` does not change the count.
  - `cnt_clr` = 1 sets both counters to 0 on that edge.
  - `cnt_clr` wins over a simultaneous increment: the count becomes 0 and that event is lost.
- **Reset**
  - `reset_n` = 0 immediately clears `s1`, `s2`, `db_cnt`, `Ta`, `Tb` and both car counters to 0, regardless of `clk`.
  - Reset mid-debounce discards the partial count.
  - After release, a sensor still held high needs the full latency again before `Ta` rises, and counts as a new car.

## Timing

- All outputs are 0 in reset.
- Latency:
  - A raw level change set up before rising edge E0 and held stable appears on `Ta` after edge E0+DB_CYCLES+1, i.e. the (DB_CYCLES+2)th edge that samples it.
  - With DB_CYCLES = 4 this is 6 edges (60 ns at a 10 ns clock).
- `car_cnt_x` updates on the same edge as the `Tx` rise. No extra latency.
- Minimum rejected glitch: any `s2` excursion of 1..DB_CYCLES-1 cycles leaves `Tx` unchanged.
- Minimum accepted pulse: an excursion of exactly DB_CYCLES cycles toggles `Tx`.
- A raw pulse narrower than one clock period may be missed by the synchronizer. This is acceptable and produces no output change.
- `Ta`/`Tb` change at most once per DB_CYCLES cycles, so the light controller never sees input glitches.

## Test plan

All scenarios use DB_CYCLES = 4, CNT_W = 8 and a 10 ns clock.

- **Reset values:** hold `reset_n` = 0 with `sa_raw` = `sb_raw` = 1 -> `Ta` = `Tb` = 0 and `car_cnt_a` = `car_cnt_b` = 0 throughout. After release, `Ta` rises on the 6th edge and `car_cnt_a` = 1.
- **Latency:** raise `sa_raw` before edge 0 -> `Ta` = 1 after edge 5, not before. Then drop `sa_raw` -> `Ta` = 0 exactly 6 edges later, with `car_cnt_a` still 1. `Tb` and `car_cnt_b` are unaffected.
- **Glitch rejection:**
  - Pulse `sb_raw` high for 3 cycles -> `Tb` stays 0 and `car_cnt_b` = 0.
  - Pulse for 4 cycles -> `Tb` = 1 for exactly 4 cycles and `car_cnt_b` = 1.
  - With `Tb` = 1, a 2-cycle low dropout -> `Tb` stays 1.
- **Saturation and clear:**
  - Drive 257 clean `sa_raw` pulses (8 high / 8 low) -> `car_cnt_a` = 255.
  - Assert `cnt_clr` for one cycle -> both counters = 0.
  - Assert `cnt_clr` on the same edge as a `Ta` rise -> count = 0.
- **Async reset mid-operation:** assert `reset_n` = 0 asynchronously, 2 cycles into a debounce and while `Tb` = 1 -> `Ta`, `Tb` and both counters = 0 within the same cycle. After release with sensors held high, both outputs rise 6 edges later and each count = 1.
